cpu_regfile: RTL and testbench

// - RISC-V integer register file x0..x31: two combinational read ports (rs1, rs2), one synchronous write port (rd).
// - Sits between decode/operand fetch and writeback in the CPU core; works for RV32 and RV64 via XLEN.
// - x0 is hardwired to zero; all other registers clear on reset.

---
 rtl/cpu_regfile.sv | 97 +++++++++
 tb/tb_cpu_regfile.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cpu_regfile
// Description : RISC-V integer register file x0..x(REG_COUNT-1).
//               Two combinational read ports and one synchronous write port.
//               x0 is a constant zero and is not stored.
//               Registers 1..REG_COUNT-1 clear asynchronously while
//               reset is low.
//               While reset is low both read ports return zero and
//               writes are ignored.
// Parameters  : XLEN      - register width, 32 or 64
//               REG_COUNT - implemented registers, 32 (RV32I/RV64I) or 16 (RV32E)
// Ports       : clk                 - clock, write captured on rising edge
//               reset               - asynchronous active-low reset
//               rs1_addr / rs2_addr - read indices
//               rs1_data / rs2_data - read data (combinational)
//               rd_addr / rd_data / rd_write_en - write port
// Config      : `define CPU_REGFILE_BYPASS_EN to forward a same-cycle
//               write to a matching read port.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_regfile #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            rd_write_en,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  // Widened to 6 bits so REG_COUNT=32 compares correctly against a 5-bit index.
  localparam logic [5:0] C_REG_COUNT = 6'(REG_COUNT);

  logic [XLEN-1:0] regs_q [1:REG_COUNT-1];
  logic [XLEN-1:0] regs_d [1:REG_COUNT-1];

  logic            wr_fire;
  logic [XLEN-1:0] rs1_stored;
  logic [XLEN-1:0] rs2_stored;

  // A write is only real when out of reset, enabled, not x0 and in range.
  assign wr_fire = reset && rd_write_en && (rd_addr != 5'd0) &&
                   ({1'b0, rd_addr} < C_REG_COUNT);

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (wr_fire && (rd_addr == 5'(i))) begin
        regs_d[i] = rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes: a loop-compare select leaves x0 and out-of-range
  // indices at the zero default without a separate range check.
  always_comb begin
    rs1_stored = '0;
    rs2_stored = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (rs1_addr == 5'(i)) rs1_stored = regs_q[i];
      if (rs2_addr == 5'(i)) rs2_stored = regs_q[i];
    end
  end

  always_comb begin
    rs1_data = rs1_stored;
    rs2_data = rs2_stored;
`ifdef CPU_REGFILE_BYPASS_EN
    // wr_fire already excludes x0, out-of-range indices and reset.
    if (wr_fire && (rs1_addr == rd_addr)) rs1_data = rd_data;
    if (wr_fire && (rs2_addr == rd_addr)) rs2_data = rd_data;
`endif
    // Reset also forces the read ports to zero, covering the bypass path.
    if (!reset) begin
      rs1_data = '0;
      rs2_data = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_regfile
// Description : Directed self-checking bench for cpu_regfile.
//               Drives two instances from the same stimulus:
//               - XLEN=32, REG_COUNT=32
//               - XLEN=64, REG_COUNT=16
//               Expected read values come from a bench-side model.
//               Each expected value is queued when stimulus is applied
//               and popped when the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rd_data32;
  logic [63:0] rd_data64;
  logic        rd_write_en;
  logic [31:0] rs1_data32, rs2_data32;
  logic [63:0] rs1_data64, rs2_data64;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          port;   // 0:rs1/32b 1:rs2/32b 2:rs1/64b 3:rs2/64b
    logic [63:0] exp;
  } sb_item_t;

  sb_item_t    sb[$];
  logic [31:0] mdl32 [32];
  logic [63:0] mdl64 [16];
  bit          in_rst;

`ifdef CPU_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  cpu_regfile #(.XLEN(32), .REG_COUNT(32)) u_dut32 (
    .clk         (clk),
    .reset       (reset),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data32),
    .rd_write_en (rd_write_en),
    .rs1_data    (rs1_data32),
    .rs2_data    (rs2_data32)
  );

  cpu_regfile #(.XLEN(64), .REG_COUNT(16)) u_dut64 (
    .clk         (clk),
    .reset       (reset),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data64),
    .rd_write_en (rd_write_en),
    .rs1_data    (rs1_data64),
    .rs2_data    (rs2_data64)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp32(input logic [4:0] a);
    if (in_rst || a == 5'd0) return 64'd0;
    return {32'd0, mdl32[a]};
  endfunction

  function automatic logic [63:0] exp64(input logic [4:0] a);
    if (in_rst || a == 5'd0 || a >= 5'd16) return 64'd0;
    return mdl64[a[3:0]];
  endfunction

  task automatic push(input string tag, input int port, input logic [63:0] exp);
    sb.push_back('{tag: tag, port: port, exp: exp});
  endtask

  // Pop every queued expectation and compare against the live outputs.
  task automatic drain();
    sb_item_t    it;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.port)
        0:       obs = {32'd0, rs1_data32};
        1:       obs = {32'd0, rs2_data32};
        2:       obs = rs1_data64;
        default: obs = rs2_data64;
      endcase
      checks++;
      assert (obs === it.exp) else begin
        failures++;
        $error("FAIL %s port%0d observed=%h expected=%h", it.tag, it.port, obs, it.exp);
      end
    end
  endtask

  task automatic read_chk(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    rs1_addr = a1;
    rs2_addr = a2;
    push({tag, ".rs1_32"}, 0, exp32(a1));
    push({tag, ".rs2_32"}, 1, exp32(a2));
    push({tag, ".rs1_64"}, 2, exp64(a1));
    push({tag, ".rs2_64"}, 3, exp64(a2));
    #1;
    drain();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d32,
                          input logic [63:0] d64, input logic en);
    @(negedge clk);
    rd_addr     = a;
    rd_data32   = d32;
    rd_data64   = d64;
    rd_write_en = en;
    @(posedge clk);
    #1;
    rd_write_en = 1'b0;
    if (en && !in_rst && a != 5'd0) begin
      mdl32[a] = d32;
      if (a < 5'd16) mdl64[a[3:0]] = d64;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl32[i] = '0;
    for (int i = 0; i < 16; i++) mdl64[i] = '0;
  endtask

  initial begin
    reset       = 1'b0;
    in_rst      = 1'b1;
    rs1_addr    = '0;
    rs2_addr    = '0;
    rd_addr     = '0;
    rd_data32   = '0;
    rd_data64   = '0;
    rd_write_en = 1'b0;
    clear_model();

    // Reset state, including a write attempt held low through an edge.
    repeat (2) @(posedge clk);
    do_write(5'd3, 32'h11111111, 64'h11111111_11111111, 1'b1);
    read_chk(5'd1, 5'd3, "in_reset");
    @(negedge clk);
    reset  = 1'b1;
    in_rst = 1'b0;
    read_chk(5'd0, 5'd31, "post_reset");
    read_chk(5'd3, 5'd15, "post_reset_wr_ignored");

    do_write(5'd1, 32'h12345678, 64'h12345678_9ABCDEF0, 1'b1);
    read_chk(5'd1, 5'd2, "wr_x1");

    do_write(5'd0, 32'hDEADBEEF, 64'hDEADBEEF_DEADBEEF, 1'b1);
    read_chk(5'd0, 5'd1, "wr_x0");

    do_write(5'd2, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
    do_write(5'd3, 32'h00000000, 64'h0, 1'b1);
    do_write(5'd4, 32'hAAAAAAAA, 64'hAAAAAAAA_AAAAAAAA, 1'b1);
    read_chk(5'd1, 5'd2, "seq_x1x2");
    read_chk(5'd3, 5'd4, "seq_x3x4");
    read_chk(5'd1, 5'd4, "seq_x1x4");
    read_chk(5'd4, 5'd4, "same_addr");

    do_write(5'd5, 32'h55555555, 64'h55555555_55555555, 1'b1);
    read_chk(5'd5, 5'd6, "x6_before");
    do_write(5'd6, 32'hAAAAAAAA, 64'hAAAAAAAA_AAAAAAAA, 1'b1);
    read_chk(5'd5, 5'd6, "x6_after");
    do_write(5'd7, 32'h00000000, 64'h0, 1'b1);
    do_write(5'd8, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1);
    read_chk(5'd7, 5'd8, "x7x8");

    // Same-cycle write and read of x9.
    @(negedge clk);
    rd_addr     = 5'd9;
    rd_data32   = 32'hCAFEF00D;
    rd_data64   = 64'hCAFEF00D_CAFEF00D;
    rd_write_en = 1'b1;
    rs1_addr    = 5'd9;
    rs2_addr    = 5'd9;
    push("bypass_pre.rs1_32", 0, BYPASS ? 64'hCAFEF00D : 64'd0);
    push("bypass_pre.rs2_32", 1, BYPASS ? 64'hCAFEF00D : 64'd0);
    push("bypass_pre.rs1_64", 2, BYPASS ? 64'hCAFEF00D_CAFEF00D : 64'd0);
    push("bypass_pre.rs2_64", 3, BYPASS ? 64'hCAFEF00D_CAFEF00D : 64'd0);
    #1;
    drain();
    @(posedge clk);
    #1;
    rd_write_en = 1'b0;
    mdl32[9] = 32'hCAFEF00D;
    mdl64[9] = 64'hCAFEF00D_CAFEF00D;
    read_chk(5'd9, 5'd9, "bypass_post");

    // Disabled write must not land.
    do_write(5'd1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    read_chk(5'd1, 5'd1, "wr_disabled");

    // Index beyond the 16-entry instance, and its last valid entry.
    do_write(5'd20, 32'h00001234, 64'h1234, 1'b1);
    read_chk(5'd20, 5'd20, "x20");
    do_write(5'd15, 32'h0F0F0F0F, 64'h0F0F0F0F_0F0F0F0F, 1'b1);
    read_chk(5'd15, 5'd20, "x15_x20");

    // Back-to-back writes to one register: last wins.
    do_write(5'd11, 32'h11110000, 64'h1111, 1'b1);
    do_write(5'd11, 32'h22220000, 64'h2222, 1'b1);
    read_chk(5'd11, 5'd10, "last_wins");

    // Asynchronous reset mid-run with a write pending in the same cycle.
    @(negedge clk);
    rd_addr     = 5'd10;
    rd_data32   = 32'h10101010;
    rd_data64   = 64'h10101010_10101010;
    rd_write_en = 1'b1;
    #1;
    reset  = 1'b0;
    in_rst = 1'b1;
    clear_model();
    read_chk(5'd1, 5'd10, "async_rst");
    @(posedge clk);
    #1;
    rd_write_en = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    in_rst = 1'b0;
    read_chk(5'd0, 5'd1, "rel_x0x1");
    read_chk(5'd2, 5'd3, "rel_x2x3");
    read_chk(5'd4, 5'd10, "rel_x4x10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
